// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time and hands
// instructions to if_id, honouring redirects, stalls and a 1-entry skid buffer.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_addr;
    logic        kill;
    logic        buf_v;
    logic [31:0] buf_inst;
    logic [31:0] buf_addr;
    logic [31:0] jump_target;
    logic        req_fire;

    // No new request while a buffered instruction is waiting to drain.
    assign imem_req_o  = (state == REQ) && !buf_v;
    assign imem_addr_o = pc;
    assign req_fire    = imem_req_o && imem_gnt_i;
    assign jump_target = {jump_addr_i[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            pend_addr    <= 32'h0;
            kill         <= 1'b0;
            buf_v        <= 1'b0;
            buf_inst     <= NOP_INST;
            buf_addr     <= 32'h0;
            inst_o       <= NOP_INST;
            inst_addr_o  <= 32'h0;
            inst_valid_o <= 1'b0;
        end else if (jump_en_i) begin
            // Redirect beats stall and any response arriving this edge.
            pc           <= jump_target;
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
            buf_v        <= 1'b0;
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        state     <= WAIT;
                        pend_addr <= pc;
                        kill      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end else begin
            if (!hold_flag_i) begin
                inst_o       <= NOP_INST;
                inst_valid_o <= 1'b0;
            end
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        state     <= WAIT;
                        pend_addr <= pc;
                        pc        <= pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                        if (kill) begin
                            kill <= 1'b0;
                        end else if (!hold_flag_i) begin
                            inst_o       <= imem_rdata_i;
                            inst_addr_o  <= pend_addr;
                            inst_valid_o <= 1'b1;
                        end else begin
                            buf_inst <= imem_rdata_i;
                            buf_addr <= pend_addr;
                            buf_v    <= 1'b1;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
            // Drain the skid buffer once the stall lifts.
            if (buf_v && !hold_flag_i) begin
                inst_o       <= buf_inst;
                inst_addr_o  <= buf_addr;
                inst_valid_o <= 1'b1;
                buf_v        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; the bench plays the imem side cycle by cycle.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int tests = 0;
    int fails = 0;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One undisturbed fetch: request in this cycle, gnt now, rvalid next cycle.
    task automatic fetch(input logic [31:0] a);
        chk("fetch_req", 32'(imem_req_o), 32'd1);
        chk("fetch_addr", imem_addr_o, a);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data_of(a);
        step();
        imem_rvalid_i = 1'b0;
        chk("fetch_valid", 32'(inst_valid_o), 32'd1);
        chk("fetch_iaddr", inst_addr_o, a);
        chk("fetch_inst", inst_o, data_of(a));
    endtask

    initial begin
        rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        step(); step();
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'd0);

        // 1: first request after BOOT, two-cycle latency
        rst = 1'b1;
        step();
        chk("t1_req", 32'(imem_req_o), 32'd1);
        chk("t1_addr", imem_addr_o, 32'h0);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("t1_wait_req", 32'(imem_req_o), 32'd0);
        chk("t1_valid_early", 32'(inst_valid_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = data_of(32'h0);
        step();
        imem_rvalid_i = 1'b0;
        chk("t1_valid", 32'(inst_valid_o), 32'd1);
        chk("t1_iaddr", inst_addr_o, 32'h0);
        chk("t1_inst", inst_o, data_of(32'h0));
        chk("t1_next", imem_addr_o, 32'h4);
        fetch(32'h4);

        // 2: gnt delayed three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req", 32'(imem_req_o), 32'd1);
            chk("t2_addr", imem_addr_o, 32'h8);
            chk("t2_valid", 32'(inst_valid_o), 32'd0);
        end
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("t2_pc_after", imem_addr_o, 32'hC);
        chk("t2_wait_req", 32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = data_of(32'h8);
        step();
        imem_rvalid_i = 1'b0;
        chk("t2_iaddr", inst_addr_o, 32'h8);
        fetch(32'hC);

        // 3: hold while the 0x10 response arrives
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        hold_flag_i = 1'b1;
        imem_rvalid_i = 1'b1; imem_rdata_i = data_of(32'h10);
        step();
        imem_rvalid_i = 1'b0;
        chk("t3_frozen_valid", 32'(inst_valid_o), 32'd0);
        chk("t3_frozen_iaddr", inst_addr_o, 32'hC);
        chk("t3_no_req", 32'(imem_req_o), 32'd0);
        step();
        chk("t3_no_req2", 32'(imem_req_o), 32'd0);
        hold_flag_i = 1'b0;
        step();
        chk("t3_drain_valid", 32'(inst_valid_o), 32'd1);
        chk("t3_drain_iaddr", inst_addr_o, 32'h10);
        chk("t3_drain_inst", inst_o, data_of(32'h10));
        chk("t3_next_req", 32'(imem_req_o), 32'd1);
        chk("t3_next_addr", imem_addr_o, 32'h14);
        fetch(32'h14);
        fetch(32'h18);
        fetch(32'h1C);

        // 4: jump in the same cycle as gnt of 0x20
        chk("t4_addr20", imem_addr_o, 32'h20);
        imem_gnt_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h203;
        step();
        imem_gnt_i = 1'b0; jump_en_i = 1'b0;
        chk("t4_valid0", 32'(inst_valid_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = data_of(32'h20);
        step();
        imem_rvalid_i = 1'b0;
        chk("t4_dropped", 32'(inst_valid_o), 32'd0);
        chk("t4_inst_nop", inst_o, NOP);
        fetch(32'h200);

        // 5: jump while held with a full buffer
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        hold_flag_i = 1'b1;
        imem_rvalid_i = 1'b1; imem_rdata_i = data_of(32'h204);
        step();
        imem_rvalid_i = 1'b0;
        chk("t5_buffered_req", 32'(imem_req_o), 32'd0);
        jump_en_i = 1'b1; jump_addr_i = 32'h200;
        step();
        jump_en_i = 1'b0; hold_flag_i = 1'b0;
        chk("t5_valid0", 32'(inst_valid_o), 32'd0);
        chk("t5_inst_nop", inst_o, NOP);
        chk("t5_req", 32'(imem_req_o), 32'd1);
        chk("t5_addr", imem_addr_o, 32'h200);
        fetch(32'h200);

        // PC wraps at the top of the address space
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFE;
        step();
        jump_en_i = 1'b0;
        fetch(32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr_o, 32'h0);

        // 6: reset while in WAIT
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        rst = 1'b0;
        step();
        chk("t6_req", 32'(imem_req_o), 32'd0);
        chk("t6_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_inst", inst_o, NOP);
        rst = 1'b1;
        step();
        chk("t6_restart_req", 32'(imem_req_o), 32'd1);
        chk("t6_restart_addr", imem_addr_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
